uart_tx_arbiter: RTL and testbench

Shares one byte-wide UART transmitter between NUM_REQ requesters using round-robin arbitration. A winner keeps the transmitter for a burst of up to MAX_BURST bytes, or until it flags its last byte. Sits between requester logic on the system clock and the transmitter, which runs on the divided UART clock. The block drives the transmitter's start input and watches its idle output, so no shared clock edge is needed.

---
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter between NUM_REQ requesters.
// Define UART_ARB_TAG_EN to prefix every grant with a header byte (8'hA0 | winner index).
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
  input  logic [NUM_REQ-1:0]            reqLast,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]         txData,
  output logic                          txStart,
  input  logic                          txIdle,
  output logic                          busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef UART_ARB_TAG_EN
  typedef enum logic [2:0] {IDLE, LOAD, START, DRAIN, TAG} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, START, DRAIN} state_t;
`endif

  // Handshake: a requester holds req high with its byte on its reqData slice;
  // ack pulses for one cycle in the cycle the byte is captured, after which it may move on.
  state_t          state;
  logic            idleMeta;
  logic            idleS;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   winIdx;
  logic            winFound;
  logic [7:0]      burstCnt;
  logic            lastQ;
  logic            endBurst;
  logic [DATA_WIDTH-1:0] winData;
  logic            winLast;
  logic            winReq;
`ifdef UART_ARB_TAG_EN
  logic            tagQ;
`endif

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == PW'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idleMeta <= 1'b0;
      idleS    <= 1'b0;
    end else begin
      idleMeta <= txIdle;
      idleS    <= idleMeta;
    end
  end

  // First requester at or after ptr, wrapping around.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!winFound && req[PW'((int'(ptr) + k) % NUM_REQ)]) begin
        winFound = 1'b1;
        winIdx   = PW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    winData = '0;
    winLast = 1'b0;
    winReq  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == PW'(i)) begin
        winData = reqData[i*DATA_WIDTH +: DATA_WIDTH];
        winLast = reqLast[i];
        winReq  = req[i];
      end
    end
  end

  always_comb begin
    endBurst = lastQ || (burstCnt == 8'(MAX_BURST)) || !winReq;
`ifdef UART_ARB_TAG_EN
    if (tagQ) endBurst = !winReq;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      winner   <= '0;
      burstCnt <= '0;
      lastQ    <= 1'b0;
      grant    <= '0;
      ack      <= '0;
      txData   <= '0;
      txStart  <= 1'b0;
`ifdef UART_ARB_TAG_EN
      tagQ     <= 1'b0;
`endif
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (idleS && winFound) begin
            winner <= winIdx;
            grant  <= onehot(winIdx);
`ifdef UART_ARB_TAG_EN
            state  <= TAG;
`else
            ack    <= onehot(winIdx);
            state  <= LOAD;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        TAG: begin
          txData  <= DATA_WIDTH'(8'hA0) | DATA_WIDTH'(winner);
          tagQ    <= 1'b1;
          txStart <= 1'b1;
          state   <= START;
        end
`endif
        LOAD: begin
          txData   <= winData;
          lastQ    <= winLast;
          burstCnt <= burstCnt + 8'd1;
          txStart  <= 1'b1;
          state    <= START;
        end
        START: begin
          if (!idleS) begin
            txStart <= 1'b0;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (idleS) begin
`ifdef UART_ARB_TAG_EN
            tagQ <= 1'b0;
`endif
            if (endBurst) begin
              ptr      <= (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);
              burstCnt <= '0;
              grant    <= '0;
              state    <= IDLE;
            end else begin
              ack   <= onehot(winner);
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a transaction-level arbitration model predicts the grant order
// and transmitted byte stream; a simple transmitter model replays txIdle.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] reqData;
  logic [NR-1:0]    reqLast;
  logic [NR-1:0]    ack;
  logic [NR-1:0]    grant;
  logic [DW-1:0]    txData;
  logic             txStart;
  logic             txIdle;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  int            exp_grant_q[$];
  logic [8:0]    drv_q[NR][$];
  logic [8:0]    mdl_q[NR][$];
  int            mdl_ptr;
  int            frame_len_fix;
  logic [NR-1:0] ack_s;
  logic [NR-1:0] prev_grant;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .reqData(reqData), .reqLast(reqLast),
    .ack(ack), .grant(grant), .txData(txData), .txStart(txStart),
    .txIdle(txIdle), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add_byte(input int i, input logic [7:0] b, input logic last);
    drv_q[i].push_back({last, b});
    mdl_q[i].push_back({last, b});
  endtask

  // Drain the model's pending bytes: whole grants, burst cap, last flag, empty queue ends a grant.
  task automatic model_run();
    int w;
    int n;
    bit done;
    logic [8:0] e;
    while (1) begin
      w = -1;
      for (int k = 0; k < NR; k++)
        if (w < 0 && mdl_q[(mdl_ptr + k) % NR].size() > 0) w = (mdl_ptr + k) % NR;
      if (w < 0) break;
      exp_grant_q.push_back(w);
`ifdef UART_ARB_TAG_EN
      exp_q.push_back(8'hA0 | 8'(w));
`endif
      n = 0;
      done = 1'b0;
      while (!done) begin
        e = mdl_q[w].pop_front();
        exp_q.push_back(e[7:0]);
        n++;
        done = e[8] || (n == MB) || (mdl_q[w].size() == 0);
      end
      mdl_ptr = (w + 1) % NR;
    end
  endtask

  task automatic pending(output bit p);
    p = 1'b0;
    for (int i = 0; i < NR; i++) if (drv_q[i].size() > 0) p = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int c;
    bit p;
    c = 0;
    pending(p);
    while (c < budget && (busy || p || exp_q.size() != 0 || txIdle == 1'b0)) begin
      @(negedge clk);
      c++;
      pending(p);
    end
    check_eq("drain_timeout", c < budget, 1);
    check_eq("bytes_left", exp_q.size(), 0);
    check_eq("grants_left", exp_grant_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_ack"}, ack, 0);
    check_eq({tag, "_grant"}, grant, 0);
    check_eq({tag, "_txstart"}, txStart, 0);
    check_eq({tag, "_txdata"}, txData, 0);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  // Transmitter: after seeing txStart it starts a frame 1..3 cycles later and holds txIdle low.
  initial begin : tx_model
    txIdle = 1'b1;
    forever begin
      @(negedge clk);
      if (txStart) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        if (exp_q.size() == 0) check_eq("frame_unexp", exp_q.size(), 1);
        else check_eq("tx_byte", txData, exp_q.pop_front());
        txIdle = 1'b0;
        repeat (frame_len_fix != 0 ? frame_len_fix : $urandom_range(4, 12)) @(posedge clk);
        #1;
        txIdle = 1'b1;
      end
    end
  end

  // Requesters present the head of their queue and pop it after each ack.
  initial begin : driver
    req = '0;
    reqData = '0;
    reqLast = '0;
    forever begin
      @(negedge clk);
      ack_s = ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (ack_s[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        if (drv_q[i].size() > 0) begin
          req[i] = 1'b1;
          reqData[i*DW +: DW] = drv_q[i][0][7:0];
          reqLast[i] = drv_q[i][0][8];
        end else begin
          req[i] = 1'b0;
          reqLast[i] = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    prev_grant = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ack != 0) begin
          check_eq("ack_onehot", $onehot(ack), 1);
          check_eq("ack_req", ack & ~req, 0);
          check_eq("ack_grant", ack, grant);
        end
        if (grant != 0 && prev_grant == 0) begin
          if (exp_grant_q.size() == 0) check_eq("grant_unexp", exp_grant_q.size(), 1);
          else check_eq("grant_owner", grant, 1 << exp_grant_q.pop_front());
        end else if (grant != 0) begin
          check_eq("grant_stable", grant, prev_grant);
        end
      end
      prev_grant = grant;
    end
  end

  initial begin : main
    int c;
    rst = 1'b1;
    frame_len_fix = 0;
    mdl_ptr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single requester with latency checks and a long frame.
    frame_len_fix = 40;
    add_byte(1, 8'h55, 1'b1);
    model_run();
    c = 0;
    do begin @(negedge clk); c++; end while (!req[1] && c < 10);
    check_eq("req1_seen", req[1], 1);
    @(negedge clk);
    check_eq("lat_grant", grant, 4'b0010);
    check_eq("lat_busy", busy, 1);
`ifndef UART_ARB_TAG_EN
    check_eq("lat_ack", ack, 4'b0010);
`endif
    @(negedge clk);
    check_eq("lat_txstart", txStart, 1);
    wait_drain(400);
    check_eq("single_txdata_hold", txData, 8'h55);
    check_eq("single_grant_free", grant, 0);
    frame_len_fix = 0;

    // Burst cap: six bytes, re-arbitration after MB.
    for (int b = 0; b < 6; b++) add_byte(2, 8'h10 + 8'(b), 1'b0);
    model_run();
    wait_drain(1500);

    // Early end: requester 3 runs dry after two bytes; requester 0 arrives mid-burst.
    add_byte(3, 8'hC1, 1'b0);
    add_byte(3, 8'hC2, 1'b0);
    model_run();
    c = 0;
    do begin @(negedge clk); c++; end while (!ack[3] && c < 100);
    check_eq("ack3_seen", ack[3], 1);
    add_byte(0, 8'h0A, 1'b1);
    model_run();
    wait_drain(1000);

    // Single last byte from requester 2 (header-prefixed when tags are enabled).
    add_byte(2, 8'h7E, 1'b1);
    model_run();
    wait_drain(500);

    // Round robin from a fresh pointer.
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mdl_ptr = 0;
    repeat (4) @(negedge clk);
    add_byte(0, 8'hA1, 1'b1);
    add_byte(0, 8'hA2, 1'b1);
    add_byte(1, 8'hB1, 1'b1);
    add_byte(2, 8'hB2, 1'b1);
    add_byte(3, 8'hB3, 1'b1);
    model_run();
    wait_drain(1500);

    // Reset while the transmitter is mid-frame.
    frame_len_fix = 30;
    add_byte(1, 8'h3C, 1'b1);
    model_run();
    c = 0;
    do begin @(negedge clk); c++; end while (!ack[1] && c < 200);
    check_eq("ack1_seen", ack[1], 1);
    c = 0;
    while (txIdle && c < 20) begin @(negedge clk); c++; end
    check_eq("frame_started", txIdle, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_zero_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mdl_ptr = 0;
    @(negedge clk);
    add_byte(2, 8'h99, 1'b1);
    model_run();
    c = 0;
    while (txIdle == 1'b0 && c < 100) begin
      check_eq("idle_gate_grant", grant, 0);
      @(negedge clk);
      c++;
    end
    frame_len_fix = 0;
    wait_drain(500);

    // Randomized traffic rounds.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NR; i++) begin
        int nb;
        nb = $urandom_range(0, 7);
        for (int b = 0; b < nb; b++)
          add_byte(i, 8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
      end
      model_run();
      wait_drain(5000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
